// File: rtl/rand_gen_pkg.sv
// rand_gen_pkg: shared types, constants and RV64I encoders for the random instruction stream generator
package rand_gen_pkg;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [6:0] OPC_OP = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI = 7'h37;
  localparam logic [6:0] OPC_OP_32 = 7'h3B;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_ADDI, OP_ANDI, OP_SLLI,
    OP_SRLI, OP_SRAI, OP_LUI, OP_ADDW, OP_SUBW, OP_ADDIW, OP_ADD2, OP_ADDI2
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_PRO, S_BODY, S_EPI, S_DONE} state_e;
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
  endfunction
endpackage

// File: rtl/gen_lfsr32.sv
// gen_lfsr32: 32-bit right-shifting Galois LFSR with seed load and step enable
module gen_lfsr32
  import rand_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [31:0] state,
  output logic [31:0] nxt
);
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;
  assign nxt = lfsr_step(state);
  // reload the seed on reset or start, otherwise advance only when stepped
  always_ff @(posedge clk)
    if (rst || load) state <= SEED_NZ;
    else if (step) state <= nxt;
endmodule

// File: rtl/rand_inst_stream_gen.sv
// rand_inst_stream_gen: emits a seeded RV64I test program (init prologue, random ALU body, ebreak) over valid/ready
module rand_inst_stream_gen
  import rand_gen_pkg::*;
#(
  parameter int          NUM_INSTS = 64,
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] SEED      = 32'hACE1_2345,
  parameter bit          ENABLE_W  = 1'b1,
  parameter int          ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_index
);
  localparam logic [4:0] MASK = 5'(NUM_REGS - 1);
  state_e st, nxt_st;
  logic [15:0] cnt;
  logic [31:0] lfsr_q, lfsr_nxt, nxt_inst;
  logic start_ok, hs, pro_last, body_last;
  function automatic logic [31:0] addi_init(input logic [4:0] r);
    return enc_i(12'(r), 5'd0, 3'd0, r, OPC_OP_IMM);
  endfunction
  function automatic logic [31:0] body_inst(input logic [31:0] l);
    logic [4:0] rd, rs1, rs2;
    op_e op;
    rd = l[8:4] & MASK;
    rd = (rd == 5'd0) ? 5'd1 : rd;
    rs1 = l[13:9] & MASK;
    rs2 = l[18:14] & MASK;
    op = op_e'(l[3:0]);
    if (!ENABLE_W)
      op = (op == OP_ADDW) ? OP_ADD : (op == OP_SUBW) ? OP_SUB : (op == OP_ADDIW) ? OP_ADDI : op;
    case (op)
      OP_ADD, OP_ADD2: body_inst = enc_r(7'h00, rs2, rs1, 3'd0, rd, OPC_OP);
      OP_SUB:          body_inst = enc_r(7'h20, rs2, rs1, 3'd0, rd, OPC_OP);
      OP_XOR:          body_inst = enc_r(7'h00, rs2, rs1, 3'd4, rd, OPC_OP);
      OP_OR:           body_inst = enc_r(7'h00, rs2, rs1, 3'd6, rd, OPC_OP);
      OP_AND:          body_inst = enc_r(7'h00, rs2, rs1, 3'd7, rd, OPC_OP);
      OP_ANDI:         body_inst = enc_i(l[31:20], rs1, 3'd7, rd, OPC_OP_IMM);
      OP_SLLI:         body_inst = enc_i({6'b000000, l[25:20]}, rs1, 3'd1, rd, OPC_OP_IMM);
      OP_SRLI:         body_inst = enc_i({6'b000000, l[25:20]}, rs1, 3'd5, rd, OPC_OP_IMM);
      OP_SRAI:         body_inst = enc_i({6'b010000, l[25:20]}, rs1, 3'd5, rd, OPC_OP_IMM);
      OP_LUI:          body_inst = enc_u(l[31:12], rd, OPC_LUI);
      OP_ADDW:         body_inst = enc_r(7'h00, rs2, rs1, 3'd0, rd, OPC_OP_32);
      OP_SUBW:         body_inst = enc_r(7'h20, rs2, rs1, 3'd0, rd, OPC_OP_32);
      OP_ADDIW:        body_inst = enc_i(l[31:20], rs1, 3'd0, rd, OPC_OP_IMM_32);
      default:         body_inst = enc_i(l[31:20], rs1, 3'd0, rd, OPC_OP_IMM);
    endcase
  endfunction
  assign o_valid = (st == S_PRO) || (st == S_BODY) || (st == S_EPI);
  assign o_busy = o_valid;
  assign o_done = st == S_DONE;
  assign hs = o_valid && i_ready;
  assign start_ok = i_start && ((st == S_IDLE) || (st == S_DONE));
  gen_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .step  (hs && (st == S_BODY)),
    .state (lfsr_q),
    .nxt   (lfsr_nxt)
  );
  // next phase and the word to present after the current one is accepted
  always_comb begin
    pro_last = cnt == 16'(NUM_REGS - 1);
    body_last = cnt == 16'(NUM_INSTS - 1);
    nxt_st = (st == S_PRO) ? (pro_last ? ((NUM_INSTS == 0) ? S_EPI : S_BODY) : S_PRO)
           : (st == S_BODY) ? (body_last ? S_EPI : S_BODY) : S_DONE;
    nxt_inst = (nxt_st == S_EPI) ? EBREAK
             : (nxt_st == S_BODY) ? body_inst((st == S_BODY) ? lfsr_nxt : lfsr_q)
             : (nxt_st == S_PRO) ? addi_init(5'(cnt + 16'd1)) : o_inst;
  end
  // sequencer: start loads the first prologue word, each handshake advances the stream
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      o_inst <= '0;
      o_addr <= BASE_ADDR;
      o_index <= '0;
      cnt <= '0;
    end else if (start_ok) begin
      st <= S_PRO;
      o_inst <= addi_init(5'd1);
      o_addr <= BASE_ADDR;
      o_index <= '0;
      cnt <= 16'd1;
    end else if (hs) begin
      st <= nxt_st;
      o_inst <= nxt_inst;
      o_addr <= o_addr + ADDR_W'(4);
      o_index <= o_index + {15'd0, o_index != 16'hFFFF};
      cnt <= (nxt_st != st) ? 16'd0 : cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_rand_inst_stream_gen.sv
// tb_rand_inst_stream_gen: randomized-handshake checks of the generated program against a spec-level model
module tb_rand_inst_stream_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
  int sel = 0;
  int checks = 0, failures = 0;
  logic va, vb, vc, ba, bb, bc, da, db, dc;
  logic [31:0] ia, ib, ic;
  logic [63:0] aa, ab, ac, last_addr;
  logic [15:0] xa, xb, xc;
  logic d_valid, d_busy, d_done;
  logic [31:0] d_inst;
  logic [63:0] d_addr;
  logic [15:0] d_index;
  logic [31:0] ref_q[$], got_q[$];

  always #5 clk = ~clk;

  rand_inst_stream_gen u_a (.clk(clk), .rst(rst), .i_start(start && sel == 0), .o_valid(va), .i_ready(ready),
    .o_inst(ia), .o_addr(aa), .o_busy(ba), .o_done(da), .o_index(xa));
  rand_inst_stream_gen #(.NUM_INSTS(1000), .ENABLE_W(1'b0)) u_b (.clk(clk), .rst(rst), .i_start(start && sel == 1),
    .o_valid(vb), .i_ready(ready), .o_inst(ib), .o_addr(ab), .o_busy(bb), .o_done(db), .o_index(xb));
  rand_inst_stream_gen #(.NUM_INSTS(0)) u_c (.clk(clk), .rst(rst), .i_start(start && sel == 2), .o_valid(vc),
    .i_ready(ready), .o_inst(ic), .o_addr(ac), .o_busy(bc), .o_done(dc), .o_index(xc));

  always_comb begin
    d_valid = (sel == 0) ? va : (sel == 1) ? vb : vc;
    d_busy = (sel == 0) ? ba : (sel == 1) ? bb : bc;
    d_done = (sel == 0) ? da : (sel == 1) ? db : dc;
    d_inst = (sel == 0) ? ia : (sel == 1) ? ib : ic;
    d_addr = (sel == 0) ? aa : (sel == 1) ? ab : ac;
    d_index = (sel == 0) ? xa : (sel == 1) ? xb : xc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rw(int f7, int rs2, int rs1, int f3, int rd, int opc);
    return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc);
  endfunction

  function automatic logic [31:0] iw(int imm, int rs1, int f3, int rd, int opc);
    return 32'((imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc);
  endfunction

  task automatic build(input int n, input bit enw);
    logic [31:0] l, w;
    int op, rd, rs1, rs2, imm, sh;
    l = 32'hACE12345;
    ref_q = {};
    for (int r = 1; r < 8; r++) ref_q.push_back(iw(r, 0, 0, r, 'h13));
    for (int i = 0; i < n; i++) begin
      op = int'(l % 16);
      rd = int'((l >> 4) % 8);
      if (rd == 0) rd = 1;
      rs1 = int'((l >> 9) % 8);
      rs2 = int'((l >> 14) % 8);
      imm = int'(l >> 20);
      sh = imm % 64;
      case (op)
        0, 14: w = rw(0, rs2, rs1, 0, rd, 'h33);
        1: w = rw(32, rs2, rs1, 0, rd, 'h33);
        2: w = rw(0, rs2, rs1, 4, rd, 'h33);
        3: w = rw(0, rs2, rs1, 6, rd, 'h33);
        4: w = rw(0, rs2, rs1, 7, rd, 'h33);
        6: w = iw(imm, rs1, 7, rd, 'h13);
        7: w = iw(sh, rs1, 1, rd, 'h13);
        8: w = iw(sh, rs1, 5, rd, 'h13);
        9: w = iw(1024 + sh, rs1, 5, rd, 'h13);
        10: w = (l & 32'hFFFFF000) | 32'((rd << 7) | 'h37);
        11: w = rw(0, rs2, rs1, 0, rd, enw ? 'h3B : 'h33);
        12: w = rw(32, rs2, rs1, 0, rd, enw ? 'h3B : 'h33);
        13: w = iw(imm, rs1, 0, rd, enw ? 'h1B : 'h13);
        default: w = iw(imm, rs1, 0, rd, 'h13);
      endcase
      ref_q.push_back(w);
      l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    end
    ref_q.push_back(32'h00100073);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int stall_at, input int stall_len, input int restart_at, input int abort_at);
    int n, cyc;
    logic [31:0] hi;
    logic [63:0] ha;
    n = 0;
    cyc = 0;
    got_q = {};
    ready = 1'b1;
    while (!d_done && cyc < 4000) begin
      check("valid", 64'(d_valid), 64'd1);
      if (n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 64'(d_valid), 64'd0);
        check("abort_busy", 64'(d_busy), 64'd0);
        check("abort_addr", d_addr, 64'd0);
        check("abort_index", 64'(d_index), 64'd0);
        return;
      end
      if (n == stall_at) begin
        ready = 1'b0;
        hi = d_inst;
        ha = d_addr;
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_inst", 64'(d_inst), 64'(hi));
          check("stall_addr", d_addr, ha);
        end
        ready = 1'b1;
      end
      check("addr", d_addr, 64'(4 * n));
      check("index", 64'(d_index), 64'(n));
      last_addr = d_addr;
      got_q.push_back(d_inst);
      start = (n == restart_at);
      n++;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("done", 64'(d_done), 64'd1);
    check("busy_end", 64'(d_busy), 64'd0);
    check("valid_end", 64'(d_valid), 64'd0);
    check("index_end", 64'(d_index), 64'(n));
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, 64'(got_q.size()), 64'(ref_q.size()));
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) check(tag, 64'(got_q[i]), 64'(ref_q[i]));
  endtask

  initial begin
    logic [31:0] w;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(d_valid), 64'd0);
    check("rst_inst", 64'(d_inst), 64'd0);
    check("rst_addr", d_addr, 64'd0);
    check("rst_busy", 64'(d_busy), 64'd0);
    check("rst_done", 64'(d_done), 64'd0);
    check("rst_index", 64'(d_index), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    build(64, 1'b1);
    pulse_start();
    collect(-1, 0, -1, -1);
    compare("run_a");
    check("first_word", 64'(got_q.size() > 0 ? got_q[0] : 32'd0), 64'h00100093);
    check("ebreak_addr", last_addr, 64'h11C);
    check("final_index", 64'(d_index), 64'd72);
    pulse_start();
    collect(7 + $urandom_range(5, 50), 5, -1, -1);
    compare("stall");
    pulse_start();
    collect(-1, 0, $urandom_range(2, 60), -1);
    compare("busy_start");
    pulse_start();
    collect(-1, 0, -1, -1);
    compare("done_start");
    pulse_start();
    collect(-1, 0, -1, 7 + $urandom_range(1, 60));
    @(negedge clk);
    pulse_start();
    collect(-1, 0, -1, -1);
    compare("after_abort");
    sel = 1;
    build(1000, 1'b0);
    @(negedge clk);
    pulse_start();
    collect(-1, 0, -1, -1);
    compare("no_w");
    for (int i = 7; i + 1 < got_q.size(); i++) begin
      w = got_q[i];
      check("w_opcode", 64'(w[6:0] == 7'h3B || w[6:0] == 7'h1B), 64'd0);
      check("rd_range", 64'(w[11:7] >= 5'd1 && w[11:7] <= 5'd7), 64'd1);
      if (w[6:0] != 7'h37) check("rs1_range", 64'(w[19:15] <= 5'd7), 64'd1);
      if (w[6:0] == 7'h33) check("rs2_range", 64'(w[24:20] <= 5'd7), 64'd1);
    end
    sel = 2;
    build(0, 1'b1);
    @(negedge clk);
    pulse_start();
    collect(-1, 0, -1, -1);
    compare("n0");
    check("n0_ebreak_addr", last_addr, 64'h1C);
    check("n0_done", 64'(d_done), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
